// File: rtl/tcp_rx_notify_reader_pkg.sv
// Shared definitions for the TCP echo kernel: notification and packet-bus field
// layout, reader FSM states and the notification-to-metadata helpers.
package tcp_kernel_pkg;
   localparam int DATA_W         = 512;
   localparam int META_W         = 88;
   localparam int BYTES_PER_BEAT = 64;
   localparam int BEAT_SHIFT     = 6;
   localparam int BEAT_CNT_W     = 10;
   localparam int REQ_W          = 32;
   localparam int RX_W           = DATA_W + 1;

   localparam int NOTIF_SESSION_LSB = 0;
   localparam int NOTIF_LEN_LSB     = 16;
   localparam int NOTIF_IP_LSB      = 32;
   localparam int NOTIF_PORT_LSB    = 64;
   localparam int NOTIF_CLOSED_BIT  = 80;
   localparam int NOTIF_RSVD_LSB    = 81;

   localparam int PKT_W          = 601;
   localparam int PKT_DATA_LSB   = 0;
   localparam int PKT_LAST_BIT   = 512;
   localparam int PKT_SESSION_LSB = 513;
   localparam int PKT_LEN_LSB    = 529;
   localparam int PKT_IP_LSB     = 545;
   localparam int PKT_PORT_LSB   = 577;
   localparam int PKT_CLOSED_BIT = 593;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DATA = 2'd2
   } state_t;

   // Packed so that it drops straight into the pkt bus above the last bit.
   typedef struct packed {
      logic        closed;
      logic [15:0] port;
      logic [31:0] ip;
      logic [15:0] length;
      logic [15:0] session;
   } meta_t;

   function automatic meta_t notif_to_meta(input logic [NOTIF_CLOSED_BIT:0] n);
      meta_t m;
      m.session = n[NOTIF_SESSION_LSB +: 16];
      m.length  = n[NOTIF_LEN_LSB +: 16];
      m.ip      = n[NOTIF_IP_LSB +: 32];
      m.port    = n[NOTIF_PORT_LSB +: 16];
      m.closed  = n[NOTIF_CLOSED_BIT];
      return m;
   endfunction

   function automatic logic [BEAT_CNT_W:0] expected_beats(input logic [15:0] len);
      logic [16:0] sum;
      sum = {1'b0, len} + 17'(BYTES_PER_BEAT - 1);
      return sum[16:BEAT_SHIFT];
   endfunction
endpackage

// File: rtl/tcp_rx_notify_reader_if.sv
// Stream bundle between the TCP/IP stack, the notify reader and the packet sender.
interface tcp_rx_notify_reader_if;
   import tcp_kernel_pkg::*;

   logic [META_W-1:0] s_axis_notifications_TDATA;
   logic              s_axis_notifications_TVALID;
   logic              s_axis_notifications_TREADY;
   logic [REQ_W-1:0]  m_axis_read_package_TDATA;
   logic              m_axis_read_package_TVALID;
   logic              m_axis_read_package_TREADY;
   logic [RX_W-1:0]   s_axis_rx_data_TDATA;
   logic              s_axis_rx_data_TVALID;
   logic              s_axis_rx_data_TREADY;
   logic [PKT_W-1:0]  pkt_tx_TDATA;
   logic              pkt_tx_TVALID;
   logic              pkt_tx_TREADY;

   modport master (
      output s_axis_notifications_TDATA, s_axis_notifications_TVALID,
      input  s_axis_notifications_TREADY,
      input  m_axis_read_package_TDATA, m_axis_read_package_TVALID,
      output m_axis_read_package_TREADY,
      output s_axis_rx_data_TDATA, s_axis_rx_data_TVALID,
      input  s_axis_rx_data_TREADY,
      input  pkt_tx_TDATA, pkt_tx_TVALID,
      output pkt_tx_TREADY
   );

   modport slave (
      input  s_axis_notifications_TDATA, s_axis_notifications_TVALID,
      output s_axis_notifications_TREADY,
      output m_axis_read_package_TDATA, m_axis_read_package_TVALID,
      input  m_axis_read_package_TREADY,
      input  s_axis_rx_data_TDATA, s_axis_rx_data_TVALID,
      output s_axis_rx_data_TREADY,
      output pkt_tx_TDATA, pkt_tx_TVALID,
      input  pkt_tx_TREADY
   );
endinterface

// File: rtl/tcp_rx_notify_reader_reg_slice.sv
// One-entry AXI-stream output register; accepts a new beat whenever the held one
// is absent or leaving in the same cycle, so a steady stream sees no bubbles.
module axis_reg_slice #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   logic         valid_reg;
   logic [W-1:0] data_reg;

   assign in_ready  = !valid_reg || out_ready;
   assign out_valid = valid_reg;
   assign out_data  = data_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
      end else if (in_ready) begin
         valid_reg <= in_valid;
         if (in_valid) begin
            data_reg <= in_data;
         end
      end
   end
endmodule

// File: rtl/tcp_rx_notify_reader.sv
// Turns stack notifications into read-package requests and forwards the returned
// payload beats, tagged with the notification metadata, to the packet sender.
module tcp_rx_notify_reader
   import tcp_kernel_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   tcp_rx_notify_reader_if.slave  bus,
   output logic                   err_len_mismatch
);
   state_t                state_reg, state_next;
   meta_t                 meta_reg;
   meta_t                 notif_meta;
   logic [BEAT_CNT_W-1:0] beat_cnt_reg;
   logic                  err_reg;
   logic                  notif_fire;
   logic                  beat_fire;
   logic                  beat_last;
   logic                  slice_in_valid;
   logic                  slice_in_ready;
   logic [PKT_W-1:0]      slice_in_data;
   logic                  unused_reserved;

   assign notif_meta      = notif_to_meta(bus.s_axis_notifications_TDATA[NOTIF_CLOSED_BIT:0]);
   assign unused_reserved = ^bus.s_axis_notifications_TDATA[META_W-1:NOTIF_RSVD_LSB];
   assign beat_last       = bus.s_axis_rx_data_TDATA[DATA_W];

   assign bus.m_axis_read_package_TDATA = {meta_reg.length, meta_reg.session};
   assign err_len_mismatch              = err_reg;

   assign slice_in_data = {{(PKT_W - PKT_CLOSED_BIT - 1){1'b0}}, meta_reg, beat_last,
                           bus.s_axis_rx_data_TDATA[DATA_W-1:0]};

   always_comb begin
      state_next                      = state_reg;
      bus.s_axis_notifications_TREADY = 1'b0;
      bus.m_axis_read_package_TVALID  = 1'b0;
      bus.s_axis_rx_data_TREADY       = 1'b0;
      slice_in_valid                  = 1'b0;
      notif_fire                      = 1'b0;
      beat_fire                       = 1'b0;
      case (state_reg)
         IDLE: begin
            // Not ready while reset is held, even though the state already reads IDLE.
            bus.s_axis_notifications_TREADY = !rst;
            notif_fire = !rst && bus.s_axis_notifications_TVALID;
            if (notif_fire && (notif_meta.length != 16'd0)) begin
               state_next = REQ;
            end
         end
         REQ: begin
            bus.m_axis_read_package_TVALID = 1'b1;
            if (bus.m_axis_read_package_TREADY) begin
               state_next = DATA;
            end
         end
         DATA: begin
            bus.s_axis_rx_data_TREADY = slice_in_ready;
            slice_in_valid = bus.s_axis_rx_data_TVALID;
            beat_fire      = bus.s_axis_rx_data_TVALID && slice_in_ready;
            if (beat_fire && beat_last) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         meta_reg     <= '0;
         beat_cnt_reg <= '0;
         err_reg      <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (notif_fire) begin
            meta_reg <= notif_meta;
         end
         if (beat_fire) begin
            if (beat_last) begin
               beat_cnt_reg <= '0;
               if (({1'b0, beat_cnt_reg} + 11'd1) != expected_beats(meta_reg.length)) begin
                  err_reg <= 1'b1;
               end
            end else begin
               beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
         end
      end
   end

   axis_reg_slice #(.W(PKT_W)) u_pkt_slice (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (slice_in_valid),
      .in_ready  (slice_in_ready),
      .in_data   (slice_in_data),
      .out_valid (bus.pkt_tx_TVALID),
      .out_ready (bus.pkt_tx_TREADY),
      .out_data  (bus.pkt_tx_TDATA)
   );
endmodule

// File: tb/tb_tcp_rx_notify_reader.sv
// Directed bench for tcp_rx_notify_reader: small packet, backpressure, empty
// notification, length mismatch, request stall and reset in mid-packet.
`timescale 1ns/1ps
module tb_tcp_rx_notify_reader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic err_len_mismatch;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   logic toggle_en = 1'b0;
   logic stall_prev = 1'b0;
   logic [600:0] prev_data = '0;
   logic [600:0] got_q[$];

   tcp_rx_notify_reader_if bus();

   tcp_rx_notify_reader dut (
      .clk              (clk),
      .rst              (rst),
      .bus              (bus),
      .err_len_mismatch (err_len_mismatch)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check_eq(input string tag, input logic [639:0] got, input logic [639:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [31:0] ip_of(input logic [15:0] sess);
      return {16'hC0A8, sess};
   endfunction

   function automatic logic [15:0] port_of(input logic [15:0] sess);
      return 16'h4000 ^ sess;
   endfunction

   function automatic logic [511:0] beat_data(input int pid, input int i);
      logic [511:0] d;
      for (int k = 0; k < 16; k++) d[k*32 +: 32] = {8'hA5, 8'(pid), 8'(k), 8'(i)};
      return d;
   endfunction

   // Layout: data[511:0], last[512], session, length, ip, port, closed[593], zeros.
   function automatic logic [600:0] exp_pkt(input logic [15:0] sess, input logic [15:0] len,
                                            input logic closed, input logic last,
                                            input logic [511:0] data);
      return {7'd0, closed, port_of(sess), ip_of(sess), len, sess, last, data};
   endfunction

   // pkt_tx ready pattern plus a negedge monitor for handshakes and stall stability
   initial begin
      bus.pkt_tx_TREADY = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.pkt_tx_TREADY = toggle_en ? ~bus.pkt_tx_TREADY : 1'b1;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               check_eq("pkt_hold_valid", bus.pkt_tx_TVALID, 1);
               check_eq("pkt_hold_data", bus.pkt_tx_TDATA, prev_data);
            end
            if (bus.pkt_tx_TVALID && bus.pkt_tx_TREADY) got_q.push_back(bus.pkt_tx_TDATA);
            stall_prev = bus.pkt_tx_TVALID && !bus.pkt_tx_TREADY;
            prev_data  = bus.pkt_tx_TDATA;
         end
      end
   end

   task automatic reset_checks(input string pfx);
      check_eq({pfx, "_notif_ready"}, bus.s_axis_notifications_TREADY, 0);
      check_eq({pfx, "_req_valid"}, bus.m_axis_read_package_TVALID, 0);
      check_eq({pfx, "_req_data"}, bus.m_axis_read_package_TDATA, 0);
      check_eq({pfx, "_rx_ready"}, bus.s_axis_rx_data_TREADY, 0);
      check_eq({pfx, "_pkt_valid"}, bus.pkt_tx_TVALID, 0);
      check_eq({pfx, "_pkt_data"}, bus.pkt_tx_TDATA, 0);
      check_eq({pfx, "_err"}, err_len_mismatch, 0);
   endtask

   task automatic do_notif(input logic [15:0] sess, input logic [15:0] len, input logic closed);
      int w = 0;
      bus.s_axis_notifications_TDATA  = {7'd0, closed, port_of(sess), ip_of(sess), len, sess};
      bus.s_axis_notifications_TVALID = 1'b1;
      while (!bus.s_axis_notifications_TREADY && w < 100) begin
         tick();
         w++;
      end
      check_eq("notif_ready", bus.s_axis_notifications_TREADY, 1);
      tick();
      bus.s_axis_notifications_TVALID = 1'b0;
      $display("notif session=%0h length=%0d closed=%0d accepted", sess, len, closed);
   endtask

   task automatic do_req(input logic [31:0] exp_word);
      check_eq("req_valid", bus.m_axis_read_package_TVALID, 1);
      check_eq("req_data", bus.m_axis_read_package_TDATA, exp_word);
      check_eq("req_notif_ready", bus.s_axis_notifications_TREADY, 0);
      bus.m_axis_read_package_TREADY = 1'b1;
      tick();
      bus.m_axis_read_package_TREADY = 1'b0;
      $display("read_package %08h issued", exp_word);
   endtask

   task automatic send_beats(input int pid, input int n, input int last_at);
      int w;
      for (int i = 0; i < n; i++) begin
         bus.s_axis_rx_data_TDATA  = {(i == last_at), beat_data(pid, i)};
         bus.s_axis_rx_data_TVALID = 1'b1;
         w = 0;
         while (!bus.s_axis_rx_data_TREADY && w < 100) begin
            tick();
            w++;
         end
         check_eq("rx_ready", bus.s_axis_rx_data_TREADY, 1);
         tick();
      end
      bus.s_axis_rx_data_TVALID = 1'b0;
   endtask

   task automatic check_pkt(input logic [15:0] sess, input logic [15:0] len, input logic closed,
                            input int pid, input int n, input int last_at);
      int w = 0;
      while (got_q.size() < n && w < 100) begin
         tick();
         w++;
      end
      tick();
      tick();
      check_eq("pkt_count", got_q.size(), n);
      for (int i = 0; i < n && i < got_q.size(); i++) begin
         check_eq($sformatf("pkt%0d_beat%0d", pid, i), got_q[i],
                  exp_pkt(sess, len, closed, (i == last_at), beat_data(pid, i)));
      end
      $display("packet %0d: %0d beats forwarded", pid, got_q.size());
      got_q.delete();
   endtask

   initial begin
      int c0;
      bus.s_axis_notifications_TDATA  = '0;
      bus.s_axis_notifications_TVALID = 1'b0;
      bus.m_axis_read_package_TREADY  = 1'b0;
      bus.s_axis_rx_data_TDATA        = '0;
      bus.s_axis_rx_data_TVALID       = 1'b0;

      repeat (3) @(posedge clk);
      #2;
      reset_checks("rst");
      rst = 1'b0;
      #1;
      check_eq("idle_after_rst", bus.s_axis_notifications_TREADY, 1);
      tick();

      // Single small packet, also checks request and output latency
      do_notif(16'h0005, 16'd40, 1'b0);
      do_req(32'h0028_0005);
      check_eq("rx_ready_after_req", bus.s_axis_rx_data_TREADY, 1);
      send_beats(1, 1, 0);
      check_eq("pkt_lat1_valid", bus.pkt_tx_TVALID, 1);
      check_eq("pkt_lat1_data", bus.pkt_tx_TDATA, exp_pkt(16'h0005, 16'd40, 1'b0, 1'b1, beat_data(1, 0)));
      check_eq("idle_after_last", bus.s_axis_notifications_TREADY, 1);
      check_pkt(16'h0005, 16'd40, 1'b0, 1, 1, 0);
      check_eq("err_small", err_len_mismatch, 0);

      // Multi-beat with pkt_tx backpressure
      toggle_en = 1'b1;
      do_notif(16'h0002, 16'd200, 1'b0);
      do_req(32'h00C8_0002);
      send_beats(2, 4, 3);
      check_pkt(16'h0002, 16'd200, 1'b0, 2, 4, 3);
      toggle_en = 1'b0;
      check_eq("err_multi", err_len_mismatch, 0);

      // Zero-length close notification is dropped; next one accepted right away
      do_notif(16'h0007, 16'd0, 1'b1);
      check_eq("zero_len_idle", bus.s_axis_notifications_TREADY, 1);
      check_eq("zero_len_no_req", bus.m_axis_read_package_TVALID, 0);

      // Length mismatch: 128 bytes expects 2 beats, 3 arrive
      do_notif(16'h0003, 16'd128, 1'b0);
      do_req(32'h0080_0003);
      c0 = cyc;
      send_beats(3, 3, 2);
      check_eq("burst_cycles", cyc - c0, 3);
      check_eq("idle_after_burst", bus.s_axis_notifications_TREADY, 1);
      check_eq("err_set", err_len_mismatch, 1);
      check_pkt(16'h0003, 16'd128, 1'b0, 3, 3, 2);

      // Request stall with an rx beat already offered
      do_notif(16'h0011, 16'd64, 1'b0);
      bus.s_axis_rx_data_TDATA  = {1'b1, beat_data(5, 0)};
      bus.s_axis_rx_data_TVALID = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check_eq("stall_req_valid", bus.m_axis_read_package_TVALID, 1);
         check_eq("stall_req_data", bus.m_axis_read_package_TDATA, 32'h0040_0011);
         check_eq("stall_rx_ready", bus.s_axis_rx_data_TREADY, 0);
         check_eq("stall_notif_ready", bus.s_axis_notifications_TREADY, 0);
         tick();
      end
      do_req(32'h0040_0011);
      send_beats(5, 1, 0);
      check_pkt(16'h0011, 16'd64, 1'b0, 5, 1, 0);
      check_eq("err_sticky", err_len_mismatch, 1);

      // Reset after beat 2 of 4, then a clean packet
      do_notif(16'h0021, 16'd256, 1'b0);
      do_req(32'h0100_0021);
      send_beats(6, 2, -1);
      rst = 1'b1;
      #1;
      reset_checks("midrst");
      got_q.delete();
      tick();
      tick();
      rst = 1'b0;
      tick();
      do_notif(16'h0009, 16'd64, 1'b0);
      do_req(32'h0040_0009);
      send_beats(9, 1, 0);
      check_pkt(16'h0009, 16'd64, 1'b0, 9, 1, 0);
      check_eq("err_after_rst", err_len_mismatch, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
